// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS control unit: opcodes, ALU function codes
// and the WAIT handshake FSM states.
package picomips_pkg;

    // Number of opcode bits that carry the instruction; any bits above these must be zero.
    localparam int OP_DEC_W = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_MULI = 3'b010,
        OP_WAIT = 3'b011,
        OP_SUB  = 3'b100,
        OP_MUL  = 3'b101,
        OP_JMP  = 3'b110,
        OP_NOP  = 3'b111
    } opcode_t;

    // The ALU and the register file use this same 2-bit function code.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10
    } alu_op_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } ctrl_state_t;

    // Even parity over an opcode-field slice. Available for any datapath
    // consumer that wants to protect the decoded field.
    function automatic logic op_parity(input logic [OP_DEC_W-1:0] op);
        return ^op;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous level input. All flops clear on reset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_sync;

    // Shift the asynchronous input through N flops; the last flop is the synchronised value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < N; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[N-1];

endmodule

// File: rtl/ctrl_decoder_fsm.sv
// picoMIPS control unit: combinational opcode decode plus the WAIT handshake FSM.
// The handshake has a synchronised dataval, an optional timeout and a sticky illegal flag.
// Decode outputs are combinational from the opcode and the state, for a single-cycle datapath.
module ctrl_decoder_fsm
    import picomips_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int SYNC    = 2,
    parameter int TMO_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           Wready,
    input  logic           dataval,
    output logic           PCincr,
    output logic           PCabsbranch,
    output logic           INen,
    output logic [1:0]     ALUfunc,
    output logic           imm,
    output logic           w,
    output logic           stall,
    output logic           timeout,
    output logic           illegal
);

    // Counter value on the last allowed WAIT cycle. It is only compared when TIMEOUT is nonzero.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_next;
    logic             r_illegal;
    logic             w_set_illegal;
    logic             w_dv_s;
    logic             w_match;
    logic             w_illegal_op;
    opcode_t          w_op;

    sync_ff #(.N(SYNC)) u_dv_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dataval),
        .q     (w_dv_s)
    );

    assign w_op         = opcode_t'(opcode[OP_DEC_W-1:0]);
    assign w_illegal_op = ((opcode >> OP_DEC_W) != '0);
    assign w_match      = (w_dv_s == Wready);
    assign illegal      = r_illegal;

    // Decode the opcode, run the WAIT handshake, then gate the control outputs while reset is high.
    always_comb begin
        PCincr        = 1'b1;
        PCabsbranch   = 1'b0;
        INen          = 1'b0;
        ALUfunc       = ALU_ADD;
        imm           = 1'b0;
        w             = 1'b0;
        stall         = 1'b0;
        timeout       = 1'b0;
        w_set_illegal = 1'b0;
        w_next_state  = RUN;
        w_cnt_next    = '0;

        if (w_illegal_op) begin
            // Outputs stay at their NOP defaults.
            w_set_illegal = 1'b1;
        end else begin
            case (w_op)
                OP_ADD:  begin w = 1'b1; INen = Wready; ALUfunc = ALU_ADD; end
                OP_SUB:  begin w = 1'b1; INen = Wready; ALUfunc = ALU_SUB; end
                OP_MUL:  begin w = 1'b1; INen = Wready; ALUfunc = ALU_MUL; end
                OP_ADDI: begin w = 1'b1; imm = 1'b1;    ALUfunc = ALU_ADD; end
                OP_MULI: begin w = 1'b1; imm = 1'b1;    ALUfunc = ALU_MUL; end
                OP_JMP:  begin PCincr = 1'b0; PCabsbranch = 1'b1; end
                default: begin end
            endcase

            if (w_op == OP_WAIT) begin
                case (r_state)
                    RUN: begin
                        if (w_match) begin
                            // Zero-cycle pass: the handshake already matches.
                            w_next_state = RUN;
                        end else begin
                            PCincr       = 1'b0;
                            stall        = 1'b1;
                            w_next_state = WAIT;
                        end
                    end
                    WAIT: begin
                        if (w_match) begin
                            // A match takes priority over a timeout in the same cycle.
                            w_next_state = RUN;
                        end else if ((TIMEOUT != 0) && (r_cnt == TMO_LAST)) begin
                            timeout      = 1'b1;
                            w_next_state = RUN;
                        end else begin
                            PCincr       = 1'b0;
                            stall        = 1'b1;
                            w_next_state = WAIT;
                            w_cnt_next   = (r_cnt == '1) ? r_cnt : r_cnt + TMO_W'(1);
                        end
                    end
                    default: begin
                        w_next_state = RUN;
                    end
                endcase
            end else begin
                // A non-WAIT opcode while waiting means the PC moved away, so drop the handshake.
                w_next_state = RUN;
            end
        end

        if (reset) begin
            PCincr      = 1'b0;
            PCabsbranch = 1'b0;
            w           = 1'b0;
            stall       = 1'b0;
            timeout     = 1'b0;
        end else begin
            PCincr      = PCincr;
        end
    end

    // Hold the FSM state, the WAIT cycle counter and the sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_illegal <= r_illegal | w_set_illegal;
        end
    end

endmodule
